memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Synthesizable memory-side block that sits directly downstream of the phoeniX core's instruction and data memory interfaces.
- Arbitrates both ports onto one single-port synchronous RAM with a 1-cycle read latency.
- Converts the core's frame mask to RAM byte enables.
- Returns read data with a one-cycle ready pulse, so the core can be wired to real memory rather than a behavioural model.

Parameters:
- ADDRESS_WIDTH, 20, RAM word-address width (2^20 words = 4 MB).
- ROUND_ROBIN, 1: 1 = alternate grants on contention; 0 = data port always wins.

Ports:
- CLK  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- instruction_memory_interface_enable  input  1  instruction request valid
- instruction_memory_interface_state  input  1  0=READ, 1=WRITE (WRITE treated as READ)
- instruction_memory_interface_address  input  32  byte address
- instruction_memory_interface_frame_mask  input  4  ignored (fetch is always a full word)
- instruction_memory_interface_data  output  32  fetched word, held until next instruction completion
- instruction_memory_interface_ready  output  1  one-cycle completion pulse
- data_memory_interface_enable  input  1  data request valid
- data_memory_interface_state  input  1  0=READ, 1=WRITE
- data_memory_interface_address  input  32  byte address
- data_memory_interface_frame_mask  input  4  bit3→byte[7:0], bit2→[15:8], bit1→[23:16], bit0→[31:24]
- data_memory_interface_write_data  input  32  store data, already lane-aligned
- data_memory_interface_read_data  output  32  load word, held until next data read completion
- data_memory_interface_ready  output  1  one-cycle completion pulse (reads and writes)
- mem_enable  output  1  RAM access strobe
- mem_write  output  1  RAM write
- mem_address  output  ADDRESS_WIDTH  word address = address[ADDRESS_WIDTH+1:2]
- mem_byte_enable  output  4  bit i → RAM bits [8i+7:8i]
- mem_write_data  output  32  RAM write data
- mem_read_data  input  32  RAM output, valid the cycle after the RAM samples a read

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state=IDLE, last_grant=INSTRUCTION.
- FSM states: IDLE, ACCESS, CAPTURE.
- IDLE:
  - Evaluates enabled requests, excluding any port whose ready is high this cycle.
  - None eligible: stay in IDLE.
  - Else grant one port: load mem_* registers, set mem_enable=1, go to ACCESS.
- ACCESS:
  - One cycle; the RAM samples mem_* at the closing edge.
  - At that edge: mem_enable←0, mem_write←0, go to CAPTURE.
- CAPTURE:
  - Granted port's ready←1.
  - On a read: that port's data register ← mem_read_data.
  - Go to IDLE. Ready is high exactly during the first IDLE cycle.
- Latency: request sampled at edge E0 → ready high in the cycle after E2. Minimum 3 cycles; one access per 4 cycles per port.
- Requester protocol:
  - Holds enable/state/address/mask/write_data stable from assertion until it sees ready.
  - May change them at the edge ending the ready cycle.
  - The ready-cycle mask prevents re-issuing the completed request.
- Contention (both eligible in IDLE):
  - ROUND_ROBIN=0: data wins.
  - ROUND_ROBIN=1: grant the port not equal to last_grant.
  - last_grant updates on every grant.
- Data write:
  - mem_write=1, mem_write_data=write_data.
  - mem_byte_enable[i] = frame_mask[3-i].
  - frame_mask=0000 still performs an access with no bytes written and pulses ready.
  - data_memory_interface_read_data is unchanged.
- Reads:
  - mem_byte_enable=1111, mem_write=0.
  - Instruction port never drives mem_write=1.
- Address: bits [1:0] and bits above ADDRESS_WIDTH+1 are ignored, so addresses wrap modulo 2^(ADDRESS_WIDTH+2).
- A request that drops enable before grant is forgotten. Dropping enable after grant does not abort the access; ready still pulses.
- Synchronous reset in any state:
  - Abandons the transaction, returns to IDLE, clears all outputs.
  - Suppresses any pending ready.
  - A RAM write already sampled is not undone.

Test Plan:
- Reset, then instruction read of 0x0000_0010 with RAM word 4 = 0x00500093 → mem_address=4, mem_enable high one cycle; instruction_ready high 3 cycles after request edge with data 0x00500093.
- Data write address 0x100, mask 1000, write_data 0x000000AB → mem_write=1, mem_byte_enable=0001, mem_address=0x40; data_ready pulses; read_data unchanged. Then full read of 0x100 returns 0xAB in byte[7:0], other bytes preserved.
- Both ports request continuously with ROUND_ROBIN=1 → grants D,I,D,I (first goes to data since last_grant resets to INSTRUCTION); each ready one cycle, never both in the same cycle. With ROUND_ROBIN=0 → data served every slot while it stays enabled.
- Requester holds enable high through ready → no duplicate access issued in the ready cycle; a new address presented after ready → next access issues the new address.
- reset asserted during ACCESS of a data read → no ready pulse; all outputs 0 next cycle; FSM in IDLE; a subsequent request completes normally.
- Address 0xFFFF_FFFC with ADDRESS_WIDTH=20 → mem_address=0xFFFFF. Instruction request with state=WRITE → mem_write stays 0 and a read is returned.

Source files
------------

// File: rtl/memory_arbiter.sv
// Arbitrates the core's instruction and data memory ports onto one single-port
// synchronous RAM (1-cycle read latency); each access is a 3-cycle IDLE->ACCESS->CAPTURE walk.
`timescale 1ns/1ps
module memory_arbiter #(
    parameter int ADDRESS_WIDTH = 20,
    parameter bit ROUND_ROBIN   = 1'b1
) (
    input  logic                     CLK,
    input  logic                     reset,

    input  logic                     instruction_memory_interface_enable,
    input  logic                     instruction_memory_interface_state,
    input  logic [31:0]              instruction_memory_interface_address,
    input  logic [3:0]               instruction_memory_interface_frame_mask,
    output logic [31:0]              instruction_memory_interface_data,
    output logic                     instruction_memory_interface_ready,

    input  logic                     data_memory_interface_enable,
    input  logic                     data_memory_interface_state,
    input  logic [31:0]              data_memory_interface_address,
    input  logic [3:0]               data_memory_interface_frame_mask,
    input  logic [31:0]              data_memory_interface_write_data,
    output logic [31:0]              data_memory_interface_read_data,
    output logic                     data_memory_interface_ready,

    output logic                     mem_enable,
    output logic                     mem_write,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [3:0]               mem_byte_enable,
    output logic [31:0]              mem_write_data,
    input  logic [31:0]              mem_read_data
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    localparam logic GRANT_INSTRUCTION = 1'b0;
    localparam logic GRANT_DATA        = 1'b1;

    // Core frame mask is MSB-first (bit3 = lowest byte); RAM byte enables are LSB-first.
    function automatic logic [3:0] frame_mask_to_byte_enable(input logic [3:0] frame_mask);
        return {frame_mask[0], frame_mask[1], frame_mask[2], frame_mask[3]};
    endfunction

    function automatic logic [ADDRESS_WIDTH-1:0] word_address(input logic [31:0] byte_address);
        return byte_address[ADDRESS_WIDTH+1:2];
    endfunction

    logic [1:0]               r_state;
    logic                     r_last_grant;
    logic                     r_grant;
    logic                     r_grant_read;
    logic                     r_mem_enable;
    logic                     r_mem_write;
    logic [ADDRESS_WIDTH-1:0] r_mem_address;
    logic [3:0]               r_mem_byte_enable;
    logic [31:0]              r_mem_write_data;
    logic [31:0]              r_instruction_data;
    logic                     r_instruction_ready;
    logic [31:0]              r_data_read_data;
    logic                     r_data_ready;

    logic w_instruction_eligible;
    logic w_data_eligible;
    logic w_any_eligible;
    logic w_grant_data;
    logic w_unused_inputs;

    // Instruction fetches are always full-word reads, so these inputs carry no information.
    assign w_unused_inputs = ^{instruction_memory_interface_state,
                               instruction_memory_interface_frame_mask};

    // A port whose ready is high is still presenting the request just completed.
    assign w_instruction_eligible = instruction_memory_interface_enable && !r_instruction_ready;
    assign w_data_eligible        = data_memory_interface_enable && !r_data_ready;
    assign w_any_eligible         = w_instruction_eligible || w_data_eligible;

    always_comb begin
        w_grant_data = w_data_eligible;
        if (w_instruction_eligible && w_data_eligible) begin
            w_grant_data = ROUND_ROBIN ? (r_last_grant == GRANT_INSTRUCTION) : 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state             <= S_IDLE;
            r_last_grant        <= GRANT_INSTRUCTION;
            r_grant             <= GRANT_INSTRUCTION;
            r_grant_read        <= 1'b0;
            r_mem_enable        <= 1'b0;
            r_mem_write         <= 1'b0;
            r_mem_address       <= '0;
            r_mem_byte_enable   <= '0;
            r_mem_write_data    <= '0;
            r_instruction_data  <= '0;
            r_instruction_ready <= 1'b0;
            r_data_read_data    <= '0;
            r_data_ready        <= 1'b0;
        end else begin
            r_instruction_ready <= 1'b0;
            r_data_ready        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_eligible) begin
                        r_mem_enable <= 1'b1;
                        r_grant      <= w_grant_data;
                        r_last_grant <= w_grant_data;
                        r_state      <= S_ACCESS;
                        if (w_grant_data) begin
                            r_mem_write       <= data_memory_interface_state;
                            r_grant_read      <= !data_memory_interface_state;
                            r_mem_address     <= word_address(data_memory_interface_address);
                            r_mem_write_data  <= data_memory_interface_write_data;
                            r_mem_byte_enable <= data_memory_interface_state
                                ? frame_mask_to_byte_enable(data_memory_interface_frame_mask)
                                : 4'b1111;
                        end else begin
                            r_mem_write       <= 1'b0;
                            r_grant_read      <= 1'b1;
                            r_mem_address     <= word_address(instruction_memory_interface_address);
                            r_mem_byte_enable <= 4'b1111;
                        end
                    end
                end
                S_ACCESS: begin
                    r_mem_enable <= 1'b0;
                    r_mem_write  <= 1'b0;
                    r_state      <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // RAM output now reflects the read sampled at the end of ACCESS.
                    if (r_grant == GRANT_DATA) begin
                        r_data_ready <= 1'b1;
                        if (r_grant_read) begin
                            r_data_read_data <= mem_read_data;
                        end
                    end else begin
                        r_instruction_ready <= 1'b1;
                        r_instruction_data  <= mem_read_data;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instruction_memory_interface_data  = r_instruction_data;
    assign instruction_memory_interface_ready = r_instruction_ready;
    assign data_memory_interface_read_data    = r_data_read_data;
    assign data_memory_interface_ready        = r_data_ready;
    assign mem_enable                         = r_mem_enable;
    assign mem_write                          = r_mem_write;
    assign mem_address                        = r_mem_address;
    assign mem_byte_enable                    = r_mem_byte_enable;
    assign mem_write_data                     = r_mem_write_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: expected RAM accesses and port responses are
// queued by the stimulus and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_memory_arbiter;

    localparam int AW = 20;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          reset;
    logic          i_en, i_state, i_ready;
    logic [31:0]   i_addr, i_data;
    logic [3:0]    i_mask;
    logic          d_en, d_state, d_ready;
    logic [31:0]   d_addr, d_wdata, d_rdata;
    logic [3:0]    d_mask;
    logic          mem_enable, mem_write;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic          b_i_en, b_d_en, b_i_ready, b_d_ready, b_mem_enable;
    logic [31:0]   b_i_addr, b_d_addr;
    logic [31:0]   b_unused_idata, b_unused_rdata, b_unused_wdata;
    logic          b_unused_write;
    logic [AW-1:0] b_mem_address;
    logic [3:0]    b_unused_be;

    memory_arbiter #(.ADDRESS_WIDTH(AW), .ROUND_ROBIN(1'b1)) u_dut (
        .CLK(CLK), .reset(reset),
        .instruction_memory_interface_enable(i_en),
        .instruction_memory_interface_state(i_state),
        .instruction_memory_interface_address(i_addr),
        .instruction_memory_interface_frame_mask(i_mask),
        .instruction_memory_interface_data(i_data),
        .instruction_memory_interface_ready(i_ready),
        .data_memory_interface_enable(d_en),
        .data_memory_interface_state(d_state),
        .data_memory_interface_address(d_addr),
        .data_memory_interface_frame_mask(d_mask),
        .data_memory_interface_write_data(d_wdata),
        .data_memory_interface_read_data(d_rdata),
        .data_memory_interface_ready(d_ready),
        .mem_enable(mem_enable), .mem_write(mem_write), .mem_address(mem_address),
        .mem_byte_enable(mem_be), .mem_write_data(mem_wdata), .mem_read_data(mem_rdata)
    );

    memory_arbiter #(.ADDRESS_WIDTH(AW), .ROUND_ROBIN(1'b0)) u_dut_fixed (
        .CLK(CLK), .reset(reset),
        .instruction_memory_interface_enable(b_i_en),
        .instruction_memory_interface_state(1'b0),
        .instruction_memory_interface_address(b_i_addr),
        .instruction_memory_interface_frame_mask(4'b1111),
        .instruction_memory_interface_data(b_unused_idata),
        .instruction_memory_interface_ready(b_i_ready),
        .data_memory_interface_enable(b_d_en),
        .data_memory_interface_state(1'b0),
        .data_memory_interface_address(b_d_addr),
        .data_memory_interface_frame_mask(4'b1111),
        .data_memory_interface_write_data(32'h0),
        .data_memory_interface_read_data(b_unused_rdata),
        .data_memory_interface_ready(b_d_ready),
        .mem_enable(b_mem_enable), .mem_write(b_unused_write), .mem_address(b_mem_address),
        .mem_byte_enable(b_unused_be), .mem_write_data(b_unused_wdata), .mem_read_data(32'h0)
    );

    // Synchronous RAM model, 1-cycle read latency, 1024 words (address aliased).
    logic [31:0] ram [0:1023];
    always @(posedge CLK) begin
        if (mem_enable === 1'b1) begin
            if (mem_write) begin
                for (int k = 0; k < 4; k++)
                    if (mem_be[k]) ram[mem_address[9:0]][8*k +: 8] <= mem_wdata[8*k +: 8];
            end else begin
                mem_rdata <= ram[mem_address[9:0]];
            end
        end
    end

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   wd;
    } acc_t;

    acc_t          acc_q[$];
    logic [AW-1:0] acc0_q[$];
    logic [31:0]   exp_i_q[$];
    logic [31:0]   exp_d_q[$];
    logic [31:0]   last_dread;
    int            checks = 0;
    int            errors = 0;
    int            lat, lat_i, lat_d;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic exp_acc(input logic wr, input logic [AW-1:0] addr, input logic [3:0] be,
                           input logic [31:0] wd);
        acc_t e;
        e.wr = wr; e.addr = addr; e.be = be; e.wd = wd;
        acc_q.push_back(e);
    endtask

    // Monitor: every RAM access and every ready pulse is matched against the queues.
    logic prev_en = 1'b0, prev_ir = 1'b0, prev_dr = 1'b0;
    always @(negedge CLK) begin
        if (mem_enable === 1'b1) begin
            if (acc_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_access unexpected addr=%h wr=%b be=%b", mem_address, mem_write, mem_be);
            end else begin
                acc_t e;
                e = acc_q.pop_front();
                check32("mem_write", {31'b0, mem_write}, {31'b0, e.wr});
                check32("mem_address", {12'b0, mem_address}, {12'b0, e.addr});
                check32("mem_byte_enable", {28'b0, mem_be}, {28'b0, e.be});
                if (e.wr) check32("mem_write_data", mem_wdata, e.wd);
            end
            check32("mem_enable_single_cycle", {31'b0, prev_en}, 32'h0);
        end
        if (i_ready === 1'b1) begin
            if (exp_i_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL instr_ready unexpected data=%h", i_data);
            end else begin
                check32("instr_data", i_data, exp_i_q.pop_front());
            end
            check32("instr_ready_single_cycle", {31'b0, prev_ir}, 32'h0);
            check32("ready_not_both", {31'b0, d_ready}, 32'h0);
        end
        if (d_ready === 1'b1) begin
            if (exp_d_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL data_ready unexpected data=%h", d_rdata);
            end else begin
                check32("data_read_data", d_rdata, exp_d_q.pop_front());
            end
            check32("data_ready_single_cycle", {31'b0, prev_dr}, 32'h0);
        end
        if (b_mem_enable === 1'b1) begin
            if (acc0_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL fixed_access unexpected addr=%h", b_mem_address);
            end else begin
                check32("fixed_priority_address", {12'b0, b_mem_address}, {12'b0, acc0_q.pop_front()});
            end
        end
        prev_en <= (mem_enable === 1'b1);
        prev_ir <= (i_ready === 1'b1);
        prev_dr <= (d_ready === 1'b1);
    end

    task automatic instr_req(input logic [31:0] addr, input logic st, input logic [31:0] exp,
                             output int latency);
        i_en = 1'b1; i_state = st; i_addr = addr; i_mask = 4'b1010;
        exp_i_q.push_back(exp);
        latency = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge CLK); #1;
            latency = n + 1;
            if (i_ready === 1'b1) break;
        end
        if (i_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL instr_timeout addr=%h actual=no_ready required=ready", addr);
        end
    endtask

    task automatic data_req(input logic [31:0] addr, input logic st, input logic [3:0] mask,
                            input logic [31:0] wdata, input logic [31:0] exp, output int latency);
        d_en = 1'b1; d_state = st; d_addr = addr; d_mask = mask; d_wdata = wdata;
        if (st) begin
            exp_d_q.push_back(last_dread);
        end else begin
            exp_d_q.push_back(exp);
            last_dread = exp;
        end
        latency = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge CLK); #1;
            latency = n + 1;
            if (d_ready === 1'b1) break;
        end
        if (d_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL data_timeout addr=%h actual=no_ready required=ready", addr);
        end
    endtask

    task automatic i_release();
        @(posedge CLK); #1;
        i_en = 1'b0;
    endtask

    task automatic d_release();
        @(posedge CLK); #1;
        d_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
        last_dread = 32'h0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        check32({tag, "_mem_enable"}, {31'b0, mem_enable}, 32'h0);
        check32({tag, "_mem_write"}, {31'b0, mem_write}, 32'h0);
        check32({tag, "_mem_address"}, {12'b0, mem_address}, 32'h0);
        check32({tag, "_mem_byte_enable"}, {28'b0, mem_be}, 32'h0);
        check32({tag, "_mem_write_data"}, mem_wdata, 32'h0);
        check32({tag, "_instr_data"}, i_data, 32'h0);
        check32({tag, "_instr_ready"}, {31'b0, i_ready}, 32'h0);
        check32({tag, "_data_read_data"}, d_rdata, 32'h0);
        check32({tag, "_data_ready"}, {31'b0, d_ready}, 32'h0);
    endtask

    task automatic wait_fixed_ready(input bit is_data, input string name);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge CLK); #1;
            seen = is_data ? (b_d_ready === 1'b1) : (b_i_ready === 1'b1);
            if (seen) break;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s actual=no_ready required=ready", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 1024; k++) ram[k] = 32'h0;
        ram[4]     = 32'h00500093;
        ram[5]     = 32'h00A00113;
        ram[6]     = 32'h00F00193;
        ram[10'h40] = 32'h11223344;
        ram[10'h41] = 32'h55667788;
        ram[10'h42] = 32'h01020304;
        ram[10'h3FF] = 32'hDEADBEEF;
        mem_rdata = 32'h0;
        i_en = 0; i_state = 0; i_addr = 0; i_mask = 0;
        d_en = 0; d_state = 0; d_addr = 0; d_mask = 0; d_wdata = 0;
        b_i_en = 0; b_i_addr = 0; b_d_en = 0; b_d_addr = 0;
        last_dread = 32'h0;
        #2;
        do_reset();
        chk_outputs_zero("reset");

        // Single instruction fetch and its latency.
        exp_acc(1'b0, 20'h4, 4'hF, 32'h0);
        instr_req(32'h0000_0010, 1'b0, 32'h00500093, lat);
        check32("instr_latency", lat, 3);
        i_release();

        // Byte-lane writes, empty-mask write, and readback.
        exp_acc(1'b1, 20'h40, 4'b0001, 32'h000000AB);
        data_req(32'h100, 1'b1, 4'b1000, 32'h000000AB, 32'h0, lat);
        d_release();
        exp_acc(1'b0, 20'h40, 4'hF, 32'h0);
        data_req(32'h100, 1'b0, 4'hF, 32'h0, 32'h112233AB, lat);
        check32("data_read_latency", lat, 3);
        d_release();
        exp_acc(1'b1, 20'h41, 4'b0000, 32'hFFFFFFFF);
        data_req(32'h104, 1'b1, 4'b0000, 32'hFFFFFFFF, 32'h0, lat);
        d_release();
        exp_acc(1'b0, 20'h41, 4'hF, 32'h0);
        data_req(32'h104, 1'b0, 4'hF, 32'h0, 32'h55667788, lat);
        d_release();
        exp_acc(1'b1, 20'h42, 4'b1010, 32'hAABBCCDD);
        data_req(32'h108, 1'b1, 4'b0101, 32'hAABBCCDD, 32'h0, lat);
        d_release();
        exp_acc(1'b0, 20'h42, 4'hF, 32'h0);
        data_req(32'h108, 1'b0, 4'hF, 32'h0, 32'hAA02CC04, lat);
        d_release();

        // Enable held through the ready cycle, then a new address.
        exp_acc(1'b0, 20'h5, 4'hF, 32'h0);
        exp_acc(1'b0, 20'h6, 4'hF, 32'h0);
        instr_req(32'h14, 1'b0, 32'h00A00113, lat);
        @(posedge CLK); #1;
        instr_req(32'h18, 1'b0, 32'h00F00193, lat);
        check32("instr_back_to_back_latency", lat, 3);
        i_release();

        // Address wrap and instruction WRITE treated as read.
        exp_acc(1'b0, 20'hFFFFF, 4'hF, 32'h0);
        data_req(32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, lat);
        d_release();
        exp_acc(1'b0, 20'h4, 4'hF, 32'h0);
        instr_req(32'h10, 1'b1, 32'h00500093, lat);
        i_release();

        // Continuous contention with round robin: D, I, D, I.
        do_reset();
        exp_acc(1'b0, 20'h40, 4'hF, 32'h0);
        exp_acc(1'b0, 20'h4,  4'hF, 32'h0);
        exp_acc(1'b0, 20'h42, 4'hF, 32'h0);
        exp_acc(1'b0, 20'h5,  4'hF, 32'h0);
        fork
            begin
                data_req(32'h100, 1'b0, 4'hF, 32'h0, 32'h112233AB, lat_d);
                @(posedge CLK); #1;
                data_req(32'h108, 1'b0, 4'hF, 32'h0, 32'hAA02CC04, lat_d);
                d_release();
            end
            begin
                instr_req(32'h10, 1'b0, 32'h00500093, lat_i);
                @(posedge CLK); #1;
                instr_req(32'h14, 1'b0, 32'h00A00113, lat_i);
                i_release();
            end
        join

        // After a data grant, simultaneous requests go to the instruction port first.
        exp_acc(1'b0, 20'h40, 4'hF, 32'h0);
        data_req(32'h100, 1'b0, 4'hF, 32'h0, 32'h112233AB, lat);
        d_release();
        @(posedge CLK); #1;
        exp_acc(1'b0, 20'h4,  4'hF, 32'h0);
        exp_acc(1'b0, 20'h41, 4'hF, 32'h0);
        fork
            begin
                instr_req(32'h10, 1'b0, 32'h00500093, lat_i);
                i_release();
            end
            begin
                data_req(32'h104, 1'b0, 4'hF, 32'h0, 32'h55667788, lat_d);
                d_release();
            end
        join

        // Reset during ACCESS of a data read: no ready, outputs cleared, then normal service.
        exp_acc(1'b0, 20'h40, 4'hF, 32'h0);
        d_en = 1'b1; d_state = 1'b0; d_addr = 32'h100; d_mask = 4'hF;
        @(posedge CLK); #1;
        reset = 1'b1;
        d_en = 1'b0;
        @(posedge CLK); #1;
        chk_outputs_zero("mid_reset");
        reset = 1'b0;
        last_dread = 32'h0;
        repeat (4) @(posedge CLK);
        #1;
        exp_acc(1'b0, 20'h4, 4'hF, 32'h0);
        instr_req(32'h10, 1'b0, 32'h00500093, lat);
        check32("post_reset_latency", lat, 3);
        i_release();

        // Fixed priority instance: data wins simultaneous contention even after a data grant.
        acc0_q.push_back(20'h80);
        b_d_en = 1'b1; b_d_addr = 32'h200;
        wait_fixed_ready(1'b1, "fixed_first_data");
        @(posedge CLK); #1;
        b_d_en = 1'b0;
        @(posedge CLK); #1;
        acc0_q.push_back(20'h81);
        acc0_q.push_back(20'hC0);
        b_d_en = 1'b1; b_d_addr = 32'h204;
        b_i_en = 1'b1; b_i_addr = 32'h300;
        wait_fixed_ready(1'b1, "fixed_contended_data");
        @(posedge CLK); #1;
        b_d_en = 1'b0;
        wait_fixed_ready(1'b0, "fixed_contended_instr");
        @(posedge CLK); #1;
        b_i_en = 1'b0;

        repeat (4) @(posedge CLK);
        #1;
        check32("acc_queue_drained", acc_q.size(), 32'h0);
        check32("fixed_queue_drained", acc0_q.size(), 32'h0);
        check32("instr_queue_drained", exp_i_q.size(), 32'h0);
        check32("data_queue_drained", exp_d_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
